// File: rtl/prog_counter_fetch_if.sv
// prog_counter_fetch_if: decoder-side control and fetch status bundle for the PC sequencer
interface prog_counter_fetch_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic             jump;
    logic             branch_en;
    logic             taken;
    logic [1:0]       targ_sel;
    logic             ack;
    logic [PC_W-1:0]  prog_ctr;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, jump, branch_en, taken, targ_sel, ack,
        input  prog_ctr, running, done, cycle_cnt
    );

    modport slave (
        input  start, jump, branch_en, taken, targ_sel, ack,
        output prog_ctr, running, done, cycle_cnt
    );
endinterface

// File: rtl/prog_counter_fetch.sv
// prog_counter_fetch: PC/fetch sequencer with constant target LUT, run handshake and cycle counter
module prog_counter_fetch #(
    parameter int              PC_W  = 10,
    parameter int              CNT_W = 16,
    parameter logic [PC_W-1:0] TARG0 = '0,
    parameter logic [PC_W-1:0] TARG1 = '0,
    parameter logic [PC_W-1:0] TARG2 = '0,
    parameter logic [PC_W-1:0] TARG3 = '0
) (
    input logic                 clk,
    input logic                 rst,
    prog_counter_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  targ;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             done;

    // Entries double as absolute jump targets and two's-complement branch offsets
    always_comb begin
        targ    = bus.targ_sel == 2'd0 ? TARG0 :
                  bus.targ_sel == 2'd1 ? TARG1 :
                  bus.targ_sel == 2'd2 ? TARG2 : TARG3;
        pc_next = bus.ack                       ? pc :
                  bus.jump                      ? targ :
                  (bus.branch_en && bus.taken)  ? pc + targ : pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state   <= RUN;
                    pc      <= '0;
                    cnt     <= '0;
                    running <= 1'b1;
                end
                RUN: begin
                    pc  <= pc_next;
                    cnt <= &cnt ? cnt : cnt + 1'b1;
                    if (bus.ack) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                HALT: if (bus.start) begin
                    state   <= RUN;
                    pc      <= '0;
                    cnt     <= '0;
                    running <= 1'b1;
                    done    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.prog_ctr  = pc;
    assign bus.cycle_cnt = cnt;
    assign bus.running   = running;
    assign bus.done      = done;
endmodule

// File: tb/tb_prog_counter_fetch.sv
// tb_prog_counter_fetch: randomized and directed checks of the PC sequencer against a behavioural model
module tb_prog_counter_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int m_st, m_pc, m_cnt;
    int lut [4] = '{10, 40, 1021, 7};

    always #5 clk = ~clk;

    prog_counter_fetch_if #(.PC_W(10), .CNT_W(16)) bus ();
    prog_counter_fetch_if #(.PC_W(10), .CNT_W(4))  sbus ();

    prog_counter_fetch #(
        .PC_W(10), .CNT_W(16),
        .TARG0(10'd10), .TARG1(10'd40), .TARG2(10'h3FD), .TARG3(10'd7)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    prog_counter_fetch #(.PC_W(10), .CNT_W(4)) sdut (.clk(clk), .rst(rst), .bus(sbus));

    task automatic drive(input logic r, s, j, b, t, input logic [1:0] sel, input logic a);
        rst = r;
        bus.start = s; bus.jump = j; bus.branch_en = b; bus.taken = t; bus.targ_sel = sel; bus.ack = a;
        @(posedge clk);
        if (r) begin
            m_st = 0; m_pc = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
            if (a) m_st = 2;
            else if (j) m_pc = lut[sel];
            else if (b && t) m_pc = (m_pc + lut[sel]) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end else if (s) begin
            m_st = 1; m_pc = 0; m_cnt = 0;
        end
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic restart();
        drive(1, 0, 0, 0, 0, 2'd0, 0);
        drive(0, 1, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 1, 2'd1, 1);
        drive(1, 1, 0, 0, 0, 2'd0, 0);
        checks += 4;
        if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", bus.prog_ctr); end
        if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.cycle_cnt); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", bus.running); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, $urandom_range(1), $urandom_range(1), $urandom_range(1), 2'($urandom_range(3)), $urandom_range(1));
            checks += 2;
            if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL idle_pc got %0d want 0", bus.prog_ctr); end
            if (bus.running !== 1'b0) begin errors++; $display("FAIL idle_running got %b want 0", bus.running); end
        end
    endtask

    task automatic test_sequential();
        drive(0, 1, 0, 0, 0, 2'd0, 0);
        checks += 3;
        if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL first_pc got %0d want 0", bus.prog_ctr); end
        if (bus.running !== 1'b1) begin errors++; $display("FAIL first_running got %b want 1", bus.running); end
        if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL first_cnt got %0d want 0", bus.cycle_cnt); end
        for (int i = 1; i <= 12; i++) begin
            drive(0, $urandom_range(1), 0, 0, 0, 2'd0, 0);
            checks += 3;
            if (bus.prog_ctr !== 10'(i)) begin errors++; $display("FAIL seq_pc got %0d want %0d", bus.prog_ctr, i); end
            if (bus.cycle_cnt !== 16'(i)) begin errors++; $display("FAIL seq_cnt got %0d want %0d", bus.cycle_cnt, i); end
            if (bus.running !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL seq_flags got %b%b want 10", bus.running, bus.done); end
        end
    endtask

    task automatic test_jump();
        restart();
        nop(5);
        drive(0, 0, 1, 0, 0, 2'd1, 0);
        checks++;
        if (bus.prog_ctr !== 10'd40) begin errors++; $display("FAIL jump_pc got %0d want 40", bus.prog_ctr); end
        drive(0, 0, 1, 1, 1, 2'd1, 0);
        checks++;
        if (bus.prog_ctr !== 10'd40) begin errors++; $display("FAIL jump_prio_pc got %0d want 40", bus.prog_ctr); end
        drive(0, 0, 1, 0, 0, 2'd3, 0);
        checks++;
        if (bus.prog_ctr !== 10'd7) begin errors++; $display("FAIL jump3_pc got %0d want 7", bus.prog_ctr); end
    endtask

    task automatic test_branch();
        restart();
        nop(20);
        drive(0, 0, 0, 1, 1, 2'd2, 0);
        checks++;
        if (bus.prog_ctr !== 10'd17) begin errors++; $display("FAIL branch_taken_pc got %0d want 17", bus.prog_ctr); end
        nop(3);
        drive(0, 0, 0, 1, 0, 2'd2, 0);
        checks++;
        if (bus.prog_ctr !== 10'd21) begin errors++; $display("FAIL branch_not_taken_pc got %0d want 21", bus.prog_ctr); end
        drive(0, 0, 0, 0, 1, 2'd2, 0);
        checks++;
        if (bus.prog_ctr !== 10'd22) begin errors++; $display("FAIL taken_only_pc got %0d want 22", bus.prog_ctr); end
    endtask

    task automatic test_wrap();
        restart();
        drive(0, 0, 0, 1, 1, 2'd2, 0);
        nop(2);
        checks++;
        if (bus.prog_ctr !== 10'd1023) begin errors++; $display("FAIL wrap_pre_pc got %0d want 1023", bus.prog_ctr); end
        nop(1);
        checks++;
        if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", bus.prog_ctr); end
        drive(0, 0, 0, 1, 1, 2'd2, 0);
        drive(0, 0, 0, 1, 1, 2'd2, 0);
        nop(2);
        checks++;
        if (bus.prog_ctr !== 10'd1020) begin errors++; $display("FAIL wrap_neg_pc got %0d want 1020", bus.prog_ctr); end
        drive(0, 0, 0, 1, 1, 2'd0, 0);
        checks++;
        if (bus.prog_ctr !== 10'd6) begin errors++; $display("FAIL branch_wrap_pc got %0d want 6", bus.prog_ctr); end
    endtask

    task automatic test_halt();
        restart();
        nop(9);
        drive(0, 0, 1, 1, 1, 2'd1, 1);
        checks += 4;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL halt_done got %b want 1", bus.done); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL halt_running got %b want 0", bus.running); end
        if (bus.prog_ctr !== 10'd9) begin errors++; $display("FAIL halt_pc got %0d want 9", bus.prog_ctr); end
        if (bus.cycle_cnt !== 16'd10) begin errors++; $display("FAIL halt_cnt got %0d want 10", bus.cycle_cnt); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, $urandom_range(1), $urandom_range(1), $urandom_range(1), 2'($urandom_range(3)), $urandom_range(1));
            checks += 3;
            if (bus.prog_ctr !== 10'd9) begin errors++; $display("FAIL frozen_pc got %0d want 9", bus.prog_ctr); end
            if (bus.cycle_cnt !== 16'd10) begin errors++; $display("FAIL frozen_cnt got %0d want 10", bus.cycle_cnt); end
            if (bus.done !== 1'b1) begin errors++; $display("FAIL frozen_done got %b want 1", bus.done); end
        end
        drive(0, 1, 0, 0, 0, 2'd0, 0);
        checks += 4;
        if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL restart_pc got %0d want 0", bus.prog_ctr); end
        if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt got %0d want 0", bus.cycle_cnt); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", bus.done); end
        if (bus.running !== 1'b1) begin errors++; $display("FAIL restart_running got %b want 1", bus.running); end
    endtask

    task automatic test_reset_mid_run();
        restart();
        nop(30);
        checks++;
        if (bus.prog_ctr !== 10'd30) begin errors++; $display("FAIL pre_reset_pc got %0d want 30", bus.prog_ctr); end
        drive(1, 1, 0, 0, 0, 2'd0, 1);
        checks += 4;
        if (bus.prog_ctr !== 10'd0) begin errors++; $display("FAIL midrst_pc got %0d want 0", bus.prog_ctr); end
        if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", bus.cycle_cnt); end
        if (bus.running !== 1'b0) begin errors++; $display("FAIL midrst_running got %b want 0", bus.running); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
                  $urandom_range(3) == 0, $urandom_range(1), 2'($urandom_range(3)), $urandom_range(19) == 0);
            checks += 4;
            if (bus.prog_ctr !== 10'(m_pc)) begin errors++; $display("FAIL rand_pc cycle %0d got %0d want %0d", i, bus.prog_ctr, m_pc); end
            if (bus.cycle_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt cycle %0d got %0d want %0d", i, bus.cycle_cnt, m_cnt); end
            if (bus.running !== (m_st == 1)) begin errors++; $display("FAIL rand_running cycle %0d got %b want %b", i, bus.running, m_st == 1); end
            if (bus.done !== (m_st == 2)) begin errors++; $display("FAIL rand_done cycle %0d got %b want %b", i, bus.done, m_st == 2); end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbus.start = 1'b1;
        @(posedge clk); #1;
        sbus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (sbus.cycle_cnt !== 4'(i > 15 ? 15 : i)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", sbus.cycle_cnt, i > 15 ? 15 : i); end
            if (sbus.prog_ctr !== 10'(i)) begin errors++; $display("FAIL sat_pc got %0d want %0d", sbus.prog_ctr, i); end
        end
    endtask

    initial begin
        bus.start = 0; bus.jump = 0; bus.branch_en = 0; bus.taken = 0; bus.targ_sel = 0; bus.ack = 0;
        sbus.start = 0; sbus.jump = 0; sbus.branch_en = 0; sbus.taken = 0; sbus.targ_sel = 0; sbus.ack = 0;
        m_st = 0; m_pc = 0; m_cnt = 0;
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid_run();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
